fetch_unit: RTL and testbench

Instruction fetch front-end for `riscv_core_min`. It generates sequential PCs, issues in-order requests to instruction memory and buffers responses in a small prefetch FIFO. It hands `{pc, instr}` pairs to the decode stage over a valid/ready handshake. On a redirect from the execute/branch logic it discards stale fetches and restarts at the new PC.

---
 rtl/fetch_unit.sv | 154 +++++++++++++++
 tb/tb_fetch_unit.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: sequential PC generator, in-order imem requests, prefetch FIFO.
// Optional macro FETCH_MISALIGN_FAULT_EN: misaligned redirect halts fetch and queues a fault entry.

module fetch_unit #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_instr,
   output logic            out_fault
);

   localparam int          CW    = $clog2(DEPTH + 1);
   localparam int          PW    = $clog2(DEPTH);
   localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] rsp_pc;
   logic [XLEN-1:0] tgt_pc;
   logic [XLEN-1:0] fifo_pc    [DEPTH];
   logic [XLEN-1:0] fifo_instr [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   outstanding_next;
   logic [CW-1:0]   drop;
   logic [CW:0]     in_use;
   logic            halted;
   logic            fault_pend;
   logic            acc;
   logic            live_rsp;
   logic            push;
   logic            pop;
   logic [XLEN-1:0] push_pc;
   logic [XLEN-1:0] push_instr;

   assign in_use = {1'b0, count} + {1'b0, outstanding};

   // gated by rst so nothing is requested while reset is held
   assign imem_req_valid = !rst && !halted && (in_use < LIMIT);
   assign imem_req_addr  = fetch_pc;

   assign acc      = imem_req_valid && imem_req_ready;
   assign live_rsp = imem_rsp_valid && (drop == '0) && !redirect_valid;
   assign push     = live_rsp || (fault_pend && !redirect_valid);
   assign pop      = out_valid && out_ready && !redirect_valid;

   assign outstanding_next = outstanding + CW'(acc) - CW'(imem_rsp_valid);

   // a pending fault entry never coincides with a live response:
   // everything in flight at the redirect is marked for dropping
   assign push_pc    = fault_pend ? fetch_pc : rsp_pc;
   assign push_instr = fault_pend ? '0 : imem_rsp_data;

   assign out_valid = (count != '0);
   assign out_pc    = out_valid ? fifo_pc[rd_ptr] : '0;
   assign out_instr = out_valid ? fifo_instr[rd_ptr] : '0;

`ifdef FETCH_MISALIGN_FAULT_EN
   logic tgt_bad;
   logic fifo_fault [DEPTH];

   assign tgt_bad   = |redirect_pc[1:0];
   assign tgt_pc    = redirect_pc;
   assign out_fault = out_valid && fifo_fault[rd_ptr];

   // halt on a misaligned target and queue its fault entry next cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         halted     <= 1'b0;
         fault_pend <= 1'b0;
      end else if (redirect_valid) begin
         halted     <= tgt_bad;
         fault_pend <= tgt_bad;
      end else begin
         fault_pend <= 1'b0;
      end
   end

   // fault marker storage alongside the FIFO payload
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_fault[wr_ptr] <= fault_pend;
      end
   end
`else
   assign halted     = 1'b0;
   assign fault_pend = 1'b0;
   assign tgt_pc     = redirect_pc & ~XLEN'(3);
   assign out_fault  = 1'b0;
`endif

   // PC, in-flight bookkeeping and FIFO occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         rsp_pc      <= RESET_PC;
         count       <= '0;
         outstanding <= '0;
         drop        <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
      end else begin
         outstanding <= outstanding_next;
         if (redirect_valid) begin
            fetch_pc <= tgt_pc;
            rsp_pc   <= tgt_pc;
            drop     <= outstanding_next;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
         end else begin
            if (acc) begin
               fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (imem_rsp_valid && (drop != '0)) begin
               drop <= drop - CW'(1);
            end
            if (live_rsp) begin
               rsp_pc <= rsp_pc + XLEN'(4);
            end
            if (push) begin
               wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   // FIFO payload, no reset needed: outputs are masked while empty
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc[wr_ptr]    <= push_pc;
         fifo_instr[wr_ptr] <= push_instr;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against an in-order
// latency-programmable instruction memory model.

module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        out_fault;

   int errors = 0;
   int checks = 0;
   int lat    = 1;
   int cyc    = 0;
   int n_acc  = 0;

   fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .out_fault      (out_fault)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mw(input logic [31:0] a);
      return a ^ 32'h5A5A_0013;
   endfunction

   // instruction memory: in-order, responds lat cycles after acceptance
   initial begin
      logic [31:0] addr_q[$];
      int          due_q[$];
      logic        rst_s, acc_s, rsp_s;
      logic [31:0] addr_s;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         #2;
         rst_s  = rst;
         acc_s  = imem_req_valid && imem_req_ready;
         addr_s = imem_req_addr;
         rsp_s  = imem_rsp_valid;
         @(posedge clk);
         #1;
         cyc++;
         if (rst_s) begin
            addr_q.delete();
            due_q.delete();
            n_acc = 0;
         end else begin
            if (rsp_s) begin
               addr_q.delete(0);
               due_q.delete(0);
            end
            if (acc_s) begin
               addr_q.push_back(addr_s);
               due_q.push_back(cyc + lat - 1);
               n_acc++;
            end
         end
         if (addr_q.size() > 0 && due_q[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mw(addr_q[0]);
         end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic restart(input int l, input logic ordy);
      rst = 1'b1;
      tick();
      tick();
      lat            = l;
      out_ready      = ordy;
      imem_req_ready = 1'b1;
      redirect_valid = 1'b0;
      rst            = 1'b0;
   endtask

   task automatic wait_valid(input int max, input string tag);
      int n = 0;
      while (!out_valid && n < max) begin
         tick();
         n++;
      end
      chk(tag, 32'(out_valid), 32'd1);
   endtask

   initial begin
      rst            = 1'b1;
      imem_req_ready = 1'b1;
      out_ready      = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      tick();
      tick();

      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_pc", out_pc, 32'h0);
      chk("rst_out_instr", out_instr, 32'h0);
      chk("rst_out_fault", 32'(out_fault), 32'd0);
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);

      // streaming, L=1
      rst = 1'b0;
      tick();
      chk("s_first_empty", 32'(out_valid), 32'd0);
      tick();
      chk("s_first_valid", 32'(out_valid), 32'd1);
      for (int i = 0; i < 6; i++) begin
         chk("s_pc", out_pc, 32'(4 * i));
         chk("s_instr", out_instr, mw(32'(4 * i)));
         tick();
      end

      // backpressure, L=2
      restart(2, 1'b0);
      repeat (10) tick();
      chk("bp_accepted", 32'(n_acc), 32'd4);
      chk("bp_req_valid", 32'(imem_req_valid), 32'd0);
      for (int i = 0; i < 6; i++) begin
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_pc", out_pc, 32'(4 * i));
         out_ready = 1'b1;
         tick();
         if (i == 0) begin
            chk("bp_resume", 32'(imem_req_valid), 32'd1);
            chk("bp_resume_addr", imem_req_addr, 32'h10);
         end
      end

      // redirect with two stale requests, L=3
      restart(3, 1'b1);
      tick();
      tick();
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      tick();
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      chk("rd_req_valid", 32'(imem_req_valid), 32'd1);
      chk("rd_req_addr", imem_req_addr, 32'h100);
      wait_valid(8, "rd_wait");
      chk("rd_pc0", out_pc, 32'h100);
      tick();
      chk("rd_pc1", out_pc, 32'h104);

      // redirect coinciding with a response and an acceptance
      restart(1, 1'b1);
      tick();
      tick();
      chk("co_pre_pc", out_pc, 32'h0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h240;
      tick();
      redirect_valid = 1'b0;
      chk("co_drop", 32'(dut.drop), 32'd1);
      chk("co_flushed", 32'(out_valid), 32'd0);
      chk("co_req_addr", imem_req_addr, 32'h240);
      tick();
      chk("co_empty", 32'(out_valid), 32'd0);
      tick();
      chk("co_valid", 32'(out_valid), 32'd1);
      chk("co_pc0", out_pc, 32'h240);
      tick();
      chk("co_pc1", out_pc, 32'h244);

      // misaligned redirect
      restart(1, 1'b1);
      tick();
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h102;
      tick();
      redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_FAULT_EN
      chk("mf_req_off", 32'(imem_req_valid), 32'd0);
      tick();
      chk("mf_valid", 32'(out_valid), 32'd1);
      chk("mf_pc", out_pc, 32'h102);
      chk("mf_instr", out_instr, 32'h0);
      chk("mf_fault", 32'(out_fault), 32'd1);
      chk("mf_req_off2", 32'(imem_req_valid), 32'd0);
      tick();
      chk("mf_single", 32'(out_valid), 32'd0);
      chk("mf_halted", 32'(imem_req_valid), 32'd0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      tick();
      redirect_valid = 1'b0;
      chk("mf_resume", 32'(imem_req_valid), 32'd1);
      chk("mf_resume_addr", imem_req_addr, 32'h200);
      tick();
      tick();
      chk("mf_new_valid", 32'(out_valid), 32'd1);
      chk("mf_new_pc", out_pc, 32'h200);
      chk("mf_new_fault", 32'(out_fault), 32'd0);
`else
      chk("ma_req_valid", 32'(imem_req_valid), 32'd1);
      chk("ma_req_addr", imem_req_addr, 32'h100);
      tick();
      tick();
      chk("ma_valid", 32'(out_valid), 32'd1);
      chk("ma_pc", out_pc, 32'h100);
      chk("ma_fault", 32'(out_fault), 32'd0);
`endif

      // reset mid-stream with the FIFO half full
      restart(1, 1'b0);
      tick();
      tick();
      tick();
      chk("mr_pre_valid", 32'(out_valid), 32'd1);
      rst = 1'b1;
      tick();
      chk("mr_out_valid", 32'(out_valid), 32'd0);
      chk("mr_req_valid", 32'(imem_req_valid), 32'd0);
      chk("mr_out_pc", out_pc, 32'h0);
      rst       = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("mr_restart", 32'(imem_req_valid), 32'd1);
      chk("mr_restart_addr", imem_req_addr, 32'h0);
      tick();
      tick();
      chk("mr_valid", 32'(out_valid), 32'd1);
      chk("mr_pc", out_pc, 32'h0);

      // PC wraps modulo 2^32
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      wait_valid(6, "wr_wait");
      chk("wr_pc0", out_pc, 32'hFFFF_FFFC);
      tick();
      chk("wr_pc1", out_pc, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
